// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store request into a single-beat data-memory access.
// Latency: DONE 2 cycles after REQ when ACK comes in the first ACCESS cycle; a rejected request gives DONE 1 cycle after REQ.
// Backpressure: REQ is only sampled in IDLE. The memory stalls the access by withholding D_MEM_ACK for up to MAX_WAIT cycles.
//
// Ports:
//   CLK, RSTn           clock, synchronous active-low reset
//   REQ, WE, FUNCT3,    request strobe, store/load select, size/sign code,
//   ADDR, WDATA         byte address and right-aligned store data (latched with REQ)
//   BUSY, DONE, ERR,    status: busy outside IDLE, one-cycle completion pulse, error flag
//   RDATA               extended load result (0 for stores and errors)
//   D_MEM_*             data-memory port: active-low CSN/WEN, byte lanes, word address,
//                       lane-aligned store data, load data and ACK
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        REQ,
   input  logic        WE,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RDATA,
   output logic        ERR,
   output logic        D_MEM_CSN,
   output logic        D_MEM_WEN,
   output logic [3:0]  D_MEM_BE,
   output logic [31:0] D_MEM_ADDR,
   output logic [31:0] D_MEM_DOUT,
   input  logic [31:0] D_MEM_DI,
   input  logic        D_MEM_ACK
);

   // The access times out in the cycle where the counter shows MAX_WAIT-1:
   // that is the MAX_WAIT-th ACCESS cycle without ACK.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Request fields that are still needed after IDLE (load extraction, WEN)
   typedef struct packed {
      logic       we;
      logic [2:0] funct3;
      logic [1:0] addr_lo;
   } req_t;

   state_t      state;
   state_t      state_nxt;
   req_t        req_q;
   logic [3:0]  be_q;
   logic [7:0]  wait_cnt;

   logic        req_err;
   logic [3:0]  be_nxt;
   logic [31:0] dout_nxt;
   logic [31:0] lane_dat;
   logic [31:0] load_dat;
   logic        timeout;

   // ------------------------------------------------------------------
   // Request decode, done on the live inputs while in IDLE
   // ------------------------------------------------------------------

   // Rejects reserved codes, unsigned stores and misaligned halves/words.
   always_comb begin
      req_err = 1'b0;
      case (FUNCT3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = ADDR[0];
         3'b010:  req_err = (ADDR[1:0] != 2'b00);
         3'b100:  req_err = WE;
         3'b101:  req_err = WE | ADDR[0];
         default: req_err = 1'b1;
      endcase
   end

   // Byte lanes and lane-replicated store data. Loads use the same lanes.
   always_comb begin
      be_nxt   = 4'b1111;
      dout_nxt = WDATA;
      case (FUNCT3[1:0])
         2'b00: begin
            be_nxt   = 4'b0001 << ADDR[1:0];
            dout_nxt = {4{WDATA[7:0]}};
         end
         2'b01: begin
            be_nxt   = 4'b0011 << ADDR[1:0];
            dout_nxt = {2{WDATA[15:0]}};
         end
         default: begin
            be_nxt   = 4'b1111;
            dout_nxt = WDATA;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load extraction from the memory word, using the latched request
   // ------------------------------------------------------------------

   // Move the addressed byte/half down to bit 0 before extending.
   assign lane_dat = D_MEM_DI >> {req_q.addr_lo, 3'b000};

   always_comb begin
      load_dat = lane_dat;
      case (req_q.funct3)
         3'b000:  load_dat = {{24{lane_dat[7]}}, lane_dat[7:0]};
         3'b001:  load_dat = {{16{lane_dat[15]}}, lane_dat[15:0]};
         3'b100:  load_dat = {24'd0, lane_dat[7:0]};
         3'b101:  load_dat = {16'd0, lane_dat[15:0]};
         default: load_dat = lane_dat;
      endcase
   end

   assign timeout = (wait_cnt == WAIT_LAST);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b1;
      DONE      = 1'b0;
      D_MEM_CSN = 1'b1;
      D_MEM_WEN = 1'b1;
      D_MEM_BE  = 4'b0000;
      case (state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (REQ) begin
               state_nxt = req_err ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            D_MEM_CSN = 1'b0;
            D_MEM_WEN = ~req_q.we;
            D_MEM_BE  = be_q;
            // ACK is checked first so a reply in the final allowed cycle still succeeds.
            if (D_MEM_ACK || timeout) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            DONE = 1'b1;
            // REQ is deliberately ignored here; a held REQ is taken again from IDLE.
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------

   // RDATA/ERR change only on the edge into RESP and hold until the next one.
   // The memory address and store data are registered at REQ time, so they
   // stay constant for the whole of ACCESS.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         req_q      <= '0;
         be_q       <= 4'b0000;
         wait_cnt   <= 8'd0;
         RDATA      <= 32'd0;
         ERR        <= 1'b0;
         D_MEM_ADDR <= 32'd0;
         D_MEM_DOUT <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (REQ) begin
                  req_q.we      <= WE;
                  req_q.funct3  <= FUNCT3;
                  req_q.addr_lo <= ADDR[1:0];
                  be_q          <= be_nxt;
                  D_MEM_ADDR    <= {ADDR[31:2], 2'b00};
                  D_MEM_DOUT    <= dout_nxt;
                  wait_cnt      <= 8'd0;
                  if (req_err) begin
                     ERR   <= 1'b1;
                     RDATA <= 32'd0;
                  end
               end
            end
            ST_ACCESS: begin
               if (D_MEM_ACK) begin
                  ERR   <= 1'b0;
                  RDATA <= req_q.we ? 32'd0 : load_dat;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (timeout) begin
                     ERR   <= 1'b1;
                     RDATA <= 32'd0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int MAX_WAIT = 15;

   logic        CLK;
   logic        RSTn;
   logic        REQ;
   logic        WE;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR;
   logic [31:0] WDATA;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RDATA;
   logic        ERR;
   logic        D_MEM_CSN;
   logic        D_MEM_WEN;
   logic [3:0]  D_MEM_BE;
   logic [31:0] D_MEM_ADDR;
   logic [31:0] D_MEM_DOUT;
   logic [31:0] D_MEM_DI;
   logic        D_MEM_ACK;

   int n_pass  = 0;
   int n_total = 0;

   load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .REQ        (REQ),
      .WE         (WE),
      .FUNCT3     (FUNCT3),
      .ADDR       (ADDR),
      .WDATA      (WDATA),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .RDATA      (RDATA),
      .ERR        (ERR),
      .D_MEM_CSN  (D_MEM_CSN),
      .D_MEM_WEN  (D_MEM_WEN),
      .D_MEM_BE   (D_MEM_BE),
      .D_MEM_ADDR (D_MEM_ADDR),
      .D_MEM_DOUT (D_MEM_DOUT),
      .D_MEM_DI   (D_MEM_DI),
      .D_MEM_ACK  (D_MEM_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [104:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0};

   // One access: REQ is driven at the current negedge, ACK given in ACCESS
   // cycle ack_at (0 = never). Expected results come from the size/sign
   // rules applied arithmetically. Returns at the negedge after DONE.
   task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] di, input int ack_at);
      int          size;
      logic        bad;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_dout;
      logic [31:0] mask;
      logic [31:0] val;
      int          exp_lat;
      int          exp_acc;
      int          cyc;
      int          acc;
      logic [31:0] rd_at_done;

      case (f3[1:0])
         2'd0:    size = 1;
         2'd1:    size = 2;
         2'd2:    size = 4;
         default: size = 0;
      endcase
      bad = (size == 0) || (f3[2] && (we || size == 4)) || (size != 0 && (addr % size) != 0);
      exp_be   = (size == 0) ? 4'h0 : 4'(((1 << size) - 1) << (addr % 4));
      exp_dout = (size == 1) ? {24'd0, wdata[7:0]} * 32'h0101_0101 :
                 (size == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 : wdata;
      exp_rdata = 32'd0;
      if (bad) begin
         exp_err = 1'b1; exp_lat = 1; exp_acc = 0;
      end else if (ack_at == 0 || ack_at > MAX_WAIT) begin
         exp_err = 1'b1; exp_lat = MAX_WAIT + 1; exp_acc = MAX_WAIT;
      end else begin
         exp_err = 1'b0; exp_lat = ack_at + 1; exp_acc = ack_at;
         if (!we) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            val  = (di >> (8 * (addr % 4))) & mask;
            if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
            exp_rdata = val;
         end
      end

      REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
      @(negedge CLK);
      REQ = 1'b0; WE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
      cyc = 1; acc = 0;
      while (!DONE && cyc < 300) begin
         D_MEM_DI = $urandom;
         if (!D_MEM_CSN) begin
            acc++;
            n_total++;
            if ({D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT} !== {~we, exp_be, addr & ~32'h3, exp_dout})
               $display("FAIL %s mem_bus cyc %0d: got wen=%b be=%b addr=%h dout=%h want wen=%b be=%b addr=%h dout=%h",
                        name, acc, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT, ~we, exp_be, addr & ~32'h3, exp_dout);
            else n_pass++;
            if (acc == ack_at) begin
               D_MEM_ACK = 1'b1; D_MEM_DI = di;
            end
         end
         @(negedge CLK);
         D_MEM_ACK = 1'b0;
         cyc++;
      end

      n_total++;
      if (!DONE || cyc !== exp_lat) $display("FAIL %s latency: got %0d (done=%b) want %0d", name, cyc, DONE, exp_lat);
      else n_pass++;
      n_total++;
      if (acc !== exp_acc) $display("FAIL %s access_cycles: got %0d want %0d", name, acc, exp_acc);
      else n_pass++;
      n_total++;
      if (ERR !== exp_err) $display("FAIL %s err: got %b want %b", name, ERR, exp_err);
      else n_pass++;
      n_total++;
      if (RDATA !== exp_rdata) $display("FAIL %s rdata: got %h want %h", name, RDATA, exp_rdata);
      else n_pass++;
      n_total++;
      if ({BUSY, D_MEM_CSN, D_MEM_WEN, D_MEM_BE} !== {1'b1, 1'b1, 1'b1, 4'h0})
         $display("FAIL %s resp_bus: got busy=%b csn=%b wen=%b be=%b want 1 1 1 0000", name, BUSY, D_MEM_CSN, D_MEM_WEN, D_MEM_BE);
      else n_pass++;
      rd_at_done = RDATA;
      @(negedge CLK);
      n_total++;
      if ({DONE, BUSY, D_MEM_CSN, RDATA} !== {1'b0, 1'b0, 1'b1, rd_at_done})
         $display("FAIL %s after_done: got done=%b busy=%b csn=%b rdata=%h want 0 0 1 %h", name, DONE, BUSY, D_MEM_CSN, RDATA, rd_at_done);
      else n_pass++;
   endtask

   task automatic test_reset();
      RSTn = 1'b0; REQ = 1'b0; WE = 1'b0; FUNCT3 = 3'd0; ADDR = 32'd0; WDATA = 32'd0;
      D_MEM_DI = 32'd0; D_MEM_ACK = 1'b0;
      repeat (2) @(negedge CLK);
      n_total++;
      if ({BUSY, DONE, ERR, RDATA, D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT} !== RESET_VEC)
         $display("FAIL reset_values: got busy=%b done=%b err=%b rdata=%h csn=%b wen=%b be=%b addr=%h dout=%h want all 0 except csn=wen=1",
                  BUSY, DONE, ERR, RDATA, D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT);
      else n_pass++;
      RSTn = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_directed();
      run_access("lb_0x103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
      n_total++;
      if ({ERR, RDATA} !== {1'b0, 32'hFFFF_FF80}) $display("FAIL lb_0x103 value: got err=%b rdata=%h want 0 ffffff80", ERR, RDATA);
      else n_pass++;
      run_access("sh_0x202", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'hDEAD_BEEF, 2);
      n_total++;
      if ({ERR, RDATA} !== {1'b0, 32'h0}) $display("FAIL sh_0x202 value: got err=%b rdata=%h want 0 00000000", ERR, RDATA);
      else n_pass++;
      run_access("lw_0x006", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1234_5678, 1);
      n_total++;
      if (ERR !== 1'b1) $display("FAIL lw_0x006 err: got %b want 1", ERR);
      else n_pass++;
      run_access("lhu_timeout", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'h0, 0);
      n_total++;
      if ({ERR, RDATA} !== {1'b1, 32'h0}) $display("FAIL lhu_timeout value: got err=%b rdata=%h want 1 00000000", ERR, RDATA);
      else n_pass++;
      run_access("lw_ack_last", 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, MAX_WAIT);
      run_access("sb_0x001", 1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'h0, 1);
      run_access("sbu_bad", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 1);
      run_access("lh_odd", 1'b0, 3'b001, 32'h0000_0031, 32'h0, 32'h0, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int          r;
         int          ack_at;
         logic [31:0] addr;
         r      = int'($urandom_range(0, 9));
         ack_at = (r == 0) ? 0 : (r == 1) ? MAX_WAIT : int'($urandom_range(1, 3));
         addr   = {20'h0, 12'($urandom)};
         run_access($sformatf("rand%0d", i), 1'($urandom), 3'($urandom), addr, $urandom, $urandom, ack_at);
      end
   endtask

   task automatic test_back_to_back();
      REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h0000_0080; WDATA = 32'h0;
      @(negedge CLK);
      n_total++;
      if (D_MEM_CSN !== 1'b0) $display("FAIL b2b first_access: got csn=%b want 0", D_MEM_CSN);
      else n_pass++;
      D_MEM_ACK = 1'b1; D_MEM_DI = 32'h1111_2222;
      @(negedge CLK);
      D_MEM_ACK = 1'b0;
      n_total++;
      if ({DONE, RDATA} !== {1'b1, 32'h1111_2222}) $display("FAIL b2b first_done: got done=%b rdata=%h want 1 11112222", DONE, RDATA);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if ({BUSY, DONE, D_MEM_CSN} !== 3'b001) $display("FAIL b2b idle_gap: got busy=%b done=%b csn=%b want 0 0 1", BUSY, DONE, D_MEM_CSN);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if ({BUSY, D_MEM_CSN} !== 2'b10) $display("FAIL b2b second_access: got busy=%b csn=%b want 1 0", BUSY, D_MEM_CSN);
      else n_pass++;
      REQ = 1'b0; D_MEM_ACK = 1'b1; D_MEM_DI = 32'h3333_4444;
      @(negedge CLK);
      D_MEM_ACK = 1'b0;
      n_total++;
      if ({DONE, RDATA} !== {1'b1, 32'h3333_4444}) $display("FAIL b2b second_done: got done=%b rdata=%h want 1 33334444", DONE, RDATA);
      else n_pass++;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_access();
      REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h0000_0044; WDATA = 32'h5555_AAAA;
      @(negedge CLK);
      REQ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_total++;
      if ({BUSY, D_MEM_CSN} !== 2'b10) $display("FAIL rst_mid third_access: got busy=%b csn=%b want 1 0", BUSY, D_MEM_CSN);
      else n_pass++;
      RSTn = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1; D_MEM_ACK = 1'b1; D_MEM_DI = 32'h7777_7777;
      n_total++;
      if ({BUSY, DONE, ERR, RDATA, D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT} !== RESET_VEC)
         $display("FAIL rst_mid reset_values: got busy=%b done=%b err=%b rdata=%h csn=%b wen=%b be=%b addr=%h dout=%h want reset values",
                  BUSY, DONE, ERR, RDATA, D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         D_MEM_ACK = 1'b0;
         n_total++;
         if ({BUSY, DONE, ERR, RDATA, D_MEM_CSN} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1})
            $display("FAIL rst_mid late_ack%0d: got busy=%b done=%b err=%b rdata=%h csn=%b want 0 0 0 00000000 1",
                     k, BUSY, DONE, ERR, RDATA, D_MEM_CSN);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
